// File: rtl/alu_branch_pkg.sv
// Shared opcode constants, ALU operation encoding and jump encodings.
package alu_branch_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  // Encoding follows {funct7b5, funct3} so R-type decode is a direct map.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_SRA   = 4'b1101,
    ALU_PASSB = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       alu_src;
    logic       auipc;
    logic       lui;
    logic [1:0] jump;
  } ctrl_t;

  // funct7b5 only distinguishes ADD/SUB and SRL/SRA; other funct3 values ignore it.
  function automatic alu_op_e funct_to_op(input logic f7b5, input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = f7b5 ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_branch_control_core.sv
// Combinational ALU datapath with Z/N/C/O flag generation.
module alu_core
  import alu_branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              zflag,
  output logic              nflag,
  output logic              cflag,
  output logic              oflag
);

  logic [DATA_W:0] sum_w;
  logic [DATA_W:0] diff_w;

  // Subtraction as a + ~b + 1 so carry-out means a >= b unsigned.
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

  // Operation select and flags; C/O only meaningful for ADD/SUB.
  always_comb begin
    result = '0;
    cflag  = 1'b0;
    oflag  = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum_w[DATA_W-1:0];
        cflag  = sum_w[DATA_W];
        oflag  = (a[DATA_W-1] == b[DATA_W-1]) && (sum_w[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result = diff_w[DATA_W-1:0];
        cflag  = diff_w[DATA_W];
        oflag  = (a[DATA_W-1] != b[DATA_W-1]) && (diff_w[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << b[4:0];
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zflag = (result == '0);
  assign nflag = result[DATA_W-1];

endmodule

// File: rtl/alu_branch_control.sv
// Instruction decode, ALU op select, branch decision and registered outputs.
module alu_branch_control
  import alu_branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zflag,
  output logic              nflag,
  output logic              cflag,
  output logic              oflag,
  output logic              branch_taken,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              mem_write,
  output logic              mem_read,
  output logic              branch,
  output logic              alu_src,
  output logic              auipc,
  output logic              lui,
  output logic [1:0]        jump
);

  ctrl_t             ctrl_d, ctrl_q;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] result_d, result_q;
  logic [3:0]        flags_d, flags_q;
  logic              z_w, n_w, c_w, o_w;
  logic              taken_d, taken_q;

  // Opcode decode into control bits and ALU operation.
  always_comb begin
    ctrl_d = '0;
    alu_op = ALU_ADD;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_write = 1'b1;
        alu_op           = funct_to_op(funct7b5, funct3);
      end
      OP_IMM: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        alu_op           = funct_to_op(funct7b5 && (funct3 == 3'b101), funct3);
      end
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.alu_src    = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_d.branch = 1'b1;
        alu_op        = ALU_SUB;
      end
      OP_JAL: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jump      = JUMP_JAL;
      end
      OP_JALR: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.jump      = JUMP_JALR;
      end
      OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.lui       = 1'b1;
        alu_op           = ALU_PASSB;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.auipc     = 1'b1;
      end
      default: begin
        ctrl_d = '0;
        alu_op = ALU_ADD;
      end
    endcase
  end

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a      (a),
    .b      (b),
    .op     (alu_op),
    .result (result_d),
    .zflag  (z_w),
    .nflag  (n_w),
    .cflag  (c_w),
    .oflag  (o_w)
  );

  assign flags_d = {z_w, n_w, c_w, o_w};

  // Branch condition from the same-cycle SUB flags; gated by branch opcode.
  always_comb begin
    taken_d = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (funct3)
        3'b000:  taken_d = z_w;
        3'b001:  taken_d = !z_w;
        3'b100:  taken_d = (n_w != o_w);
        3'b101:  taken_d = (n_w == o_w);
        3'b110:  taken_d = !c_w;
        3'b111:  taken_d = c_w;
        default: taken_d = 1'b0;
      endcase
    end
  end

  // Output registers; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      taken_q  <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      taken_q  <= taken_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign result       = result_q;
  assign {zflag, nflag, cflag, oflag} = flags_q;
  assign branch_taken = taken_q;
  assign reg_write    = ctrl_q.reg_write;
  assign mem_to_reg   = ctrl_q.mem_to_reg;
  assign mem_write    = ctrl_q.mem_write;
  assign mem_read     = ctrl_q.mem_read;
  assign branch       = ctrl_q.branch;
  assign alu_src      = ctrl_q.alu_src;
  assign auipc        = ctrl_q.auipc;
  assign lui          = ctrl_q.lui;
  assign jump         = ctrl_q.jump;

endmodule

// File: tb/tb_alu_branch_control.sv
// Table-driven bench with an expected-result queue for alu_branch_control.
module tb_alu_branch_control;

  logic        clk, rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        zflag, nflag, cflag, oflag, branch_taken;
  logic        reg_write, mem_to_reg, mem_write, mem_read, branch, alu_src, auipc, lui;
  logic [1:0]  jump;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;    // {z,n,c,o}
    logic        bt;
    logic [9:0]  ctrl;  // {rw,m2r,mw,mr,br,src,auipc,lui,jump[1:0]}
  } exp_t;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  alu_branch_control #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .a(a), .b(b), .result(result), .zflag(zflag), .nflag(nflag), .cflag(cflag),
    .oflag(oflag), .branch_taken(branch_taken), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .mem_read(mem_read),
    .branch(branch), .alu_src(alu_src), .auipc(auipc), .lui(lui), .jump(jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] ctrl_now();
    return {reg_write, mem_to_reg, mem_write, mem_read, branch, alu_src, auipc, lui, jump};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input exp_t e);
    chk({name, " result"}, result, e.res);
    chk({name, " flags"}, {28'd0, zflag, nflag, cflag, oflag}, {28'd0, e.fl});
    chk({name, " taken"}, {31'd0, branch_taken}, {31'd0, e.bt});
    chk({name, " ctrl"}, {22'd0, ctrl_now()}, {22'd0, e.ctrl});
  endtask

  task automatic check_zero(input string name);
    exp_t z;
    z.res = '0; z.fl = '0; z.bt = 1'b0; z.ctrl = '0;
    check_out(name, z);
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op; funct3 = v.f3; funct7b5 = v.f7; a = v.a; b = v.b;
  endtask

  // Drive on falling edge, queue expectation, compare after the rising edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    sb_q.push_back(v.e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb_q.pop_front();
      check_out(v.name, e);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] r, input logic [3:0] fl, input logic bt,
                              input logic [9:0] c);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.a = va; v.b = vb;
    v.e.res = r; v.e.fl = fl; v.e.bt = bt; v.e.ctrl = c;
    return v;
  endfunction

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, UND = 7'b1111111;
  localparam logic [9:0] C_R = 10'b1000000000, C_I = 10'b1000010000, C_BR = 10'b0000100000;

  vec_t add_ovf;

  initial begin
    vecs.push_back(mk("add_ovf", R, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0101, 1'b0, C_R));
    vecs.push_back(mk("sub_eq", R, 3'b000, 1'b1, 32'd5, 32'd5, 32'h0, 4'b1010, 1'b0, C_R));
    vecs.push_back(mk("sub_neg", R, 3'b000, 1'b1, 32'd0, 32'd1, 32'hFFFFFFFF, 4'b0100, 1'b0, C_R));
    vecs.push_back(mk("slt_bnd", R, 3'b010, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h1, 4'b0000, 1'b0, C_R));
    vecs.push_back(mk("sltu_bnd", R, 3'b011, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h0, 4'b1000, 1'b0, C_R));
    vecs.push_back(mk("xor", R, 3'b100, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 4'b0100, 1'b0, C_R));
    vecs.push_back(mk("or", R, 3'b110, 1'b0, 32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 4'b0000, 1'b0, C_R));
    vecs.push_back(mk("and", R, 3'b111, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 4'b0000, 1'b0, C_R));
    vecs.push_back(mk("sll_mask", R, 3'b001, 1'b0, 32'h1, 32'h21, 32'h2, 4'b0000, 1'b0, C_R));
    vecs.push_back(mk("srl31", R, 3'b101, 1'b0, 32'h80000000, 32'd31, 32'h1, 4'b0000, 1'b0, C_R));
    vecs.push_back(mk("sra31", R, 3'b101, 1'b1, 32'h80000000, 32'd31, 32'hFFFFFFFF, 4'b0100, 1'b0, C_R));
    vecs.push_back(mk("add_carry", R, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1010, 1'b0, C_R));
    vecs.push_back(mk("add_negovf", R, 3'b000, 1'b0, 32'h80000000, 32'h80000000, 32'h0, 4'b1011, 1'b0, C_R));
    vecs.push_back(mk("srai", I, 3'b101, 1'b1, 32'h80000000, 32'd4, 32'hF8000000, 4'b0100, 1'b0, C_I));
    vecs.push_back(mk("srli", I, 3'b101, 1'b0, 32'h80000000, 32'd4, 32'h08000000, 4'b0000, 1'b0, C_I));
    vecs.push_back(mk("addi_f7", I, 3'b000, 1'b1, 32'd10, 32'd3, 32'd13, 4'b0000, 1'b0, C_I));
    vecs.push_back(mk("bltu", BR, 3'b110, 1'b0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 4'b0110, 1'b0, C_BR));
    vecs.push_back(mk("blt", BR, 3'b100, 1'b0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 4'b0110, 1'b1, C_BR));
    vecs.push_back(mk("beq", BR, 3'b000, 1'b0, 32'd7, 32'd7, 32'h0, 4'b1010, 1'b1, C_BR));
    vecs.push_back(mk("bne", BR, 3'b001, 1'b0, 32'd7, 32'd7, 32'h0, 4'b1010, 1'b0, C_BR));
    vecs.push_back(mk("bge", BR, 3'b101, 1'b0, 32'd1, 32'd2, 32'hFFFFFFFF, 4'b0100, 1'b0, C_BR));
    vecs.push_back(mk("bgeu", BR, 3'b111, 1'b0, 32'd2, 32'd1, 32'h1, 4'b0010, 1'b1, C_BR));
    vecs.push_back(mk("br_010", BR, 3'b010, 1'b0, 32'd0, 32'd0, 32'h0, 4'b1010, 1'b0, C_BR));
    vecs.push_back(mk("undef", UND, 3'b000, 1'b1, 32'd5, 32'd6, 32'd11, 4'b0000, 1'b0, 10'b0));
    vecs.push_back(mk("jalr", JALR, 3'b000, 1'b0, 32'd100, 32'd4, 32'd104, 4'b0000, 1'b0, 10'b1000010010));
    vecs.push_back(mk("lui", LUI, 3'b000, 1'b0, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 4'b0000, 1'b0, 10'b1000010100));
    vecs.push_back(mk("auipc", AUIPC, 3'b000, 1'b0, 32'h1000, 32'h2000, 32'h3000, 4'b0000, 1'b0, 10'b1000011000));
    vecs.push_back(mk("load", LD, 3'b010, 1'b0, 32'h100, 32'hFFFFFFFC, 32'hFC, 4'b0010, 1'b0, 10'b1101010000));
    vecs.push_back(mk("store_z", ST, 3'b000, 1'b0, 32'd0, 32'd0, 32'h0, 4'b1000, 1'b0, 10'b0010010000));
    vecs.push_back(mk("jal", JAL, 3'b000, 1'b0, 32'd200, 32'd4, 32'd204, 4'b0000, 1'b0, 10'b1000000001));
    add_ovf = vecs[0];

    rst = 1'b1; opcode = R; funct3 = 3'b000; funct7b5 = 1'b0; a = 32'h7FFFFFFF; b = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Async reset mid-cycle, held across an edge, then first capture after release.
    apply(add_ovf);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("rst_release");
    @(posedge clk);
    #1;
    check_out("first_capture", add_ovf.e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_branch_control.md
ALU_BRANCH_CONTROL -- requirements
Module: alu_branch_control

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width (only 32 is supported).
REQ-002 SHALL have port: clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: opcode  input  7  instr[6:0]; funct3  input  3  instr[14:12]; funct7b5  input  1  instr[30].
REQ-005 SHALL have ports: a  input  32  operand A (rs1 or PC, muxed externally); b  input  32  operand B (rs2 or immediate, muxed externally).
REQ-006 SHALL have ports: result  output  32  ALU result; zflag, nflag, cflag, oflag  output  1 each  ALU flags.
REQ-007 SHALL have port: branch_taken  output  1  conditional branch decision.
REQ-008 SHALL have 1-bit control outputs: reg_write, mem_to_reg, mem_write, mem_read, branch, alu_src, auipc, lui; and jump  output  2  (01 JAL, 10 JALR).

Function
REQ-009 SHALL register every output; inputs sampled at rising edge N appear on the outputs after edge N (latency 1 cycle). No combinational input-to-output path.
REQ-010 SHALL decode opcode (control bits not listed are 0):
- 0110011 R: reg_write
- 0010011 I-ALU: reg_write, alu_src
- 0000011 load: reg_write, mem_to_reg, mem_read, alu_src
- 0100011 store: mem_write, alu_src
- 1100011 branch: branch
- 1101111 JAL: reg_write, jump=01
- 1100111 JALR: reg_write, alu_src, jump=10
- 0110111 LUI: reg_write, alu_src, lui
- 0010111 AUIPC: reg_write, alu_src, auipc
- any other opcode: all control outputs 0, ALU op ADD.
REQ-011 SHALL select the ALU operation as follows: R-type uses {funct7b5,funct3}; I-ALU uses funct3, with funct7b5 honoured only for funct3=101 (SRAI vs SRLI); branch forces SUB; LUI passes b; load, store, JAL, JALR, AUIPC and undefined opcodes force ADD.
REQ-012 SHALL implement ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount b[4:0]), SLT (signed) and SLTU (unsigned); SLT/SLTU results are 32'd1 or 32'd0; arithmetic wraps modulo 2^32.
REQ-013 SHALL set zflag=(result==0) and nflag=result[31] for every operation.
REQ-014 SHALL set cflag to the carry-out of bit 31 for ADD and for SUB (computed as a+~b+1, so cflag=1 means a>=b unsigned); oflag to two's-complement overflow for ADD/SUB; both 0 for all other operations.
REQ-015 SHALL compute branch_taken from the same-cycle flags, and only when the opcode is branch (0 otherwise):
- 000 BEQ: Z
- 001 BNE: !Z
- 100 BLT: N!=O
- 101 BGE: N==O
- 110 BLTU: !C
- 111 BGEU: C
- 010/011: 0.
REQ-016 SHALL keep SLT/SLTU correct at signed boundaries (e.g. 0x80000000 < 0x7FFFFFFF signed, > unsigned).

Reset
REQ-017 SHALL clear result, all flags, branch_taken, jump and every control output to 0 immediately on rst assertion, independent of clk.
REQ-018 SHALL hold all outputs at 0 while rst is high; the first capture occurs at the first rising clk edge after rst deasserts.

Structure
REQ-019 SHALL place the opcode constants, the 4-bit ALU operation encoding and the jump encodings in a shared package (alu_branch_pkg).
REQ-020 SHALL implement the arithmetic/logic datapath and flag generation as one combinational sub-module, alu_core; decode, branch logic and output registers stay in the top.

Verification
REQ-021 SHALL cover R-type ADD: a=0x7FFFFFFF, b=1, funct7b5=0, funct3=000 -> next cycle result=0x80000000, N=1, O=1, C=0, Z=0, reg_write=1.
REQ-022 SHALL cover branch BLTU vs BLT: opcode 1100011, a=0xFFFFFFFF, b=1 -> funct3=110 gives branch_taken=0; funct3=100 gives branch_taken=1; branch=1 in both cases.
REQ-023 SHALL cover I-ALU SRAI: opcode 0010011, funct3=101, funct7b5=1, a=0x80000000, b=4 -> result=0xF8000000; with funct7b5=0 -> result=0x08000000.
REQ-024 SHALL cover decode of the undefined opcode 1111111 -> all controls 0; JALR -> jump=10, alu_src=1, reg_write=1; LUI with b=0x12345000 -> result=0x12345000, lui=1.
REQ-025 SHALL cover async reset: assert rst mid-cycle after result=0x80000000 -> all outputs 0 before the next clk edge; they stay 0 until the first edge after release.
